// File: rtl/resampler_pkg.sv
// Shared constants and state encoding for the 160/147 resampler and its output buffer.
package resampler_pkg;

    localparam int DWIDTH              = 16;
    localparam int FIFO_DEPTH          = 16;
    localparam int FIFO_ADDR_LOG       = 4;
    localparam int DIV_DEFAULT         = 100;
    localparam int DIV_LOG_DEFAULT     = 7;
    localparam int START_LEVEL_DEFAULT = 8;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/resample_out_buffer_if.sv
// Filter-side req/ack word handshake plus the DAC-side sample strobe of the output buffer.
interface resample_out_buffer_if #(
    parameter int DW = resampler_pkg::DWIDTH
);

    logic          req_in;
    logic          ack_in;
    logic [DW-1:0] data_in;
    logic          dac_valid;
    logic [DW-1:0] dac_data;

    modport master (
        output req_in,
        output data_in,
        input  ack_in,
        input  dac_valid,
        input  dac_data
    );

    modport slave (
        input  req_in,
        input  data_in,
        output ack_in,
        output dac_valid,
        output dac_data
    );

endinterface

// File: rtl/resample_strobe_gen.sv
// Free-running divide-by-DIV counter; strobe is high on the last count of each period.
module resample_strobe_gen #(
    parameter int DIV     = resampler_pkg::DIV_DEFAULT,
    parameter int DIV_LOG = resampler_pkg::DIV_LOG_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic strobe
);

    localparam logic [DIV_LOG-1:0] DIV_MAX = DIV_LOG'(DIV - 1);
    localparam logic [DIV_LOG-1:0] DIV_ONE = DIV_LOG'(1);

    logic [DIV_LOG-1:0] div_q;
    logic [DIV_LOG-1:0] div_d;

    // Next count: wrap to zero after DIV-1.
    always_comb begin
        div_d = div_q;
        if (div_q == DIV_MAX) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign strobe = (div_q == DIV_MAX);

endmodule

// File: rtl/resample_out_buffer.sv
// Circular FIFO between the resampling filter and the DAC, drained one word every DIV clocks.
// Optional RESAMPLE_OUT_STATS_EN adds saturating stall and underrun counters.
module resample_out_buffer
    import resampler_pkg::*;
#(
    parameter int DWIDTH      = resampler_pkg::DWIDTH,
    parameter int DEPTH       = resampler_pkg::FIFO_DEPTH,
    parameter int ADDR_LOG    = resampler_pkg::FIFO_ADDR_LOG,
    parameter int DIV         = resampler_pkg::DIV_DEFAULT,
    parameter int DIV_LOG     = resampler_pkg::DIV_LOG_DEFAULT,
    parameter int START_LEVEL = resampler_pkg::START_LEVEL_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    resample_out_buffer_if.slave bus,
`ifdef RESAMPLE_OUT_STATS_EN
    output logic [15:0]         stall_cnt,
    output logic [15:0]         underrun_cnt,
`endif
    output logic                underflow,
    output logic [ADDR_LOG:0]   level
);

    localparam logic [ADDR_LOG:0]   LVL_FULL  = (ADDR_LOG+1)'(DEPTH);
    localparam logic [ADDR_LOG:0]   LVL_START = (ADDR_LOG+1)'(START_LEVEL);
    localparam logic [ADDR_LOG:0]   LVL_ONE   = (ADDR_LOG+1)'(1);
    localparam logic [ADDR_LOG-1:0] PTR_ONE   = ADDR_LOG'(1);

    logic [DWIDTH-1:0]   mem_q [DEPTH];
    logic [ADDR_LOG-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_LOG-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_LOG:0]   level_q, level_d;
    logic                ack_q, ack_d;
    logic                dac_valid_q, dac_valid_d;
    logic [DWIDTH-1:0]   dac_data_q, dac_data_d;
    logic                underflow_q, underflow_d;
    buf_state_e          state_q, state_d;
    logic                strobe_s;
    logic                wr_en_s;
    logic                rd_en_s;

    resample_strobe_gen #(
        .DIV     (DIV),
        .DIV_LOG (DIV_LOG)
    ) u_strobe (
        .clk    (clk),
        .rst    (rst),
        .strobe (strobe_s)
    );

    // Handshake, drain FSM, pointer and occupancy next-state logic.
    always_comb begin
        ack_d       = ack_q;
        wr_en_s     = 1'b0;
        rd_en_s     = 1'b0;
        dac_valid_d = 1'b0;
        dac_data_d  = dac_data_q;
        underflow_d = underflow_q;
        state_d     = state_q;

        // ack is a one-cycle grant; a grant without req just expires.
        if (ack_q) begin
            ack_d   = 1'b0;
            wr_en_s = bus.req_in;
        end else if (bus.req_in && (level_q < LVL_FULL)) begin
            ack_d = 1'b1;
        end else begin
            ack_d = 1'b0;
        end

        case (state_q)
            FILL: begin
                if (level_q >= LVL_START) begin
                    state_d = RUN;
                end else begin
                    state_d = FILL;
                end
            end
            RUN: begin
                if (strobe_s) begin
                    dac_valid_d = 1'b1;
                    if (level_q != '0) begin
                        rd_en_s    = 1'b1;
                        dac_data_d = mem_q[rd_ptr_q];
                    end else begin
                        underflow_d = 1'b1;
                    end
                end else begin
                    dac_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_en_s, rd_en_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ack_q       <= 1'b0;
            dac_valid_q <= 1'b0;
            dac_data_q  <= '0;
            underflow_q <= 1'b0;
            state_q     <= FILL;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ack_q       <= ack_d;
            dac_valid_q <= dac_valid_d;
            dac_data_q  <= dac_data_d;
            underflow_q <= underflow_d;
            state_q     <= state_d;
        end
    end

    // Sample storage; stale contents are unreachable after reset since pointers restart at zero.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

`ifdef RESAMPLE_OUT_STATS_EN
    logic [15:0] stall_q, stall_d;
    logic [15:0] underrun_q, underrun_d;

    // Saturating event counters.
    always_comb begin
        if (bus.req_in && (level_q == LVL_FULL) && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end else begin
            stall_d = stall_q;
        end
        if ((state_q == RUN) && strobe_s && (level_q == '0) && (underrun_q != 16'hFFFF)) begin
            underrun_d = underrun_q + 16'd1;
        end else begin
            underrun_d = underrun_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q    <= 16'd0;
            underrun_q <= 16'd0;
        end else begin
            stall_q    <= stall_d;
            underrun_q <= underrun_d;
        end
    end

    assign stall_cnt    = stall_q;
    assign underrun_cnt = underrun_q;
`endif

    assign bus.ack_in    = ack_q;
    assign bus.dac_valid = dac_valid_q;
    assign bus.dac_data  = dac_data_q;
    assign underflow     = underflow_q;
    assign level         = level_q;

endmodule
